// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - shared types and the one-bit shift step for seq_shifter
// Optional rotate support is enabled by defining SEQ_SHIFTER_ROTATE_EN.
package seq_shifter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  // Widest operand the step function handles; WIDTH must not exceed this.
  localparam int MAX_WIDTH     = 64;
  localparam int MSB_W         = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Shift data one position. The operand is zero-extended into MAX_WIDTH
  // bits and msb marks the operand's top bit; the caller truncates back.
  function automatic logic [MAX_WIDTH-1:0] shift_step(
    input logic [MAX_WIDTH-1:0] data,
    input shift_op_t            op,
    input logic [MSB_W-1:0]     msb
  );
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_SRL: r = data >> 1;
      OP_SRA: begin
        r      = data >> 1;
        r[msb] = data[msb];
      end
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR: begin
        r      = data >> 1;
        r[msb] = data[0];
      end
`endif
      // SLL, and op 11 when rotate is not built in
      default: r = data << 1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle one-bit-per-clock SLL/SRL/SRA shifter with valid/ready (ROR with SEQ_SHIFTER_ROTATE_EN)
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  shift_op_t          op_q, op_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [WIDTH-1:0]   stepped;

  // Next-state, datapath step and registered-output values.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    count_d    = count_q;
    op_d       = op_q;
    out_data_d = out_data_q;
    stepped    = WIDTH'(shift_step(MAX_WIDTH'(data_q), op_q, MSB_W'(WIDTH - 1)));

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          count_d = in_shamt;
          op_d    = shift_op_t'(in_op);
          if (in_shamt != '0) begin
            state_d = S_SHIFT;
          end else begin
            // Zero shift goes straight to the result with the operand unchanged.
            state_d    = S_DONE;
            out_data_d = in_data;
          end
        end
      end
      S_SHIFT: begin
        data_d  = stepped;
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d    = S_DONE;
          out_data_d = stepped;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are decoded from the next state so they are registered.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      count_q     <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      count_q     <= count_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter (expectations follow SEQ_SHIFTER_ROTATE_EN)
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  seq_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-amount result computed directly from the operation's definition.
  function automatic logic [31:0] model_result(input logic [31:0] d, input int s, input logic [1:0] op);
    case (op)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return 32'($signed(d) >>> s);
      default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (s == 0) return d;
        return (d >> s) | (d << (32 - s));
`else
        return d << s;
`endif
      end
    endcase
  endfunction

  // Transaction-level model: one pending operation with the cycle its result appears.
  bit          m_pending = 1'b0;
  bit          m_zero    = 1'b1;
  logic [31:0] m_result  = '0;
  int          m_rdy     = 0;
  int          cyc       = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("mon_in_ready", in_ready, !m_pending);
        chk("mon_out_valid", out_valid, m_pending && cyc >= m_rdy);
        if (m_pending && cyc >= m_rdy) chk("mon_out_data", out_data, m_result);
        else if (m_zero) chk("mon_out_data_zero", out_data, 32'h0);
      end
      if (!rst_n) begin
        m_pending = 1'b0;
        m_zero    = 1'b1;
      end else if (!m_pending && in_valid) begin
        m_pending = 1'b1;
        m_zero    = 1'b0;
        m_result  = model_result(in_data, int'(in_shamt), in_op);
        m_rdy     = cyc + int'(in_shamt) + 1;
      end else if (m_pending && cyc >= m_rdy && out_ready) begin
        m_pending = 1'b0;
      end
      cyc++;
    end
  end

  // Offer an operand from posedge+1 and return at posedge+1 right after its accept edge.
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready never rose");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Wait for out_valid after an accept and check latency and data against literals.
  task automatic wait_result(input string name, input int lat_exp, input logic [31:0] d_exp);
    int k = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: out_valid never rose", name);
    end else begin
      chk({name, "_latency"}, 32'(k), 32'(lat_exp));
      chk({name, "_data"}, out_data, d_exp);
      chk({name, "_in_ready_low"}, in_ready, 1'b0);
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    check_en = 1'b1;
    @(posedge clk);
    #1;

    send(32'hE0000000, 5'd3, 2'b10);
    wait_result("sra3", 4, 32'hFC000000);
    drain();

    send(32'h0000000F, 5'd4, 2'b00);
    wait_result("sll4", 5, 32'h000000F0);
    drain();

    send(32'h80000000, 5'd31, 2'b01);
    wait_result("srl31", 32, 32'h00000001);
    drain();

    send(32'h12345678, 5'd0, 2'b10);
    wait_result("sra0", 1, 32'h12345678);
    drain();

    send(32'h12345678, 5'd0, 2'b01);
    wait_result("srl0", 1, 32'h12345678);
    drain();

    send(32'h9ABCDEF1, 5'd7, 2'b10);
    wait_result("sra7", 8, 32'hFF3579BD);
    drain();

    // Backpressure with a second operand offered during DONE
    send(32'h80000000, 5'd1, 2'b10);
    wait_result("bp", 2, 32'hC0000000);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h00000003;
    in_shamt = 5'd2;
    in_op    = 2'b00;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, 32'hC0000000);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_hs_in_ready", in_ready, 1'b1);
    chk("bp_after_hs_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result("bp_second", 3, 32'h0000000C);
    drain();

    // Synchronous reset in the middle of a long shift
    send(32'h0000ABCD, 5'd10, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, 32'h0);
    repeat (15) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Op 11 is rotate right when built in, otherwise a left shift
    send(32'h00000001, 5'd1, 2'b11);
`ifdef SEQ_SHIFTER_ROTATE_EN
    wait_result("op11", 2, 32'h80000000);
`else
    wait_result("op11", 2, 32'h00000002);
`endif
    drain();

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
